// File: rtl/var_state_pkg.sv
// Shared types and default constants for the variable state / trail block.
package var_state_pkg;

  localparam int DEF_NUM_VARS     = 64;
  localparam int DEF_NUM_RD_PORTS = 5;
  localparam int DEF_MAX_LEVEL    = 63;

  // Stored level field is sized for the largest supported MAX_LEVEL (255);
  // the top zero-extends incoming levels and truncates on the read ports.
  localparam int LVL_W_MAX = 8;

  typedef struct packed {
    logic                 unassign;
    logic                 val;
    logic [LVL_W_MAX-1:0] level;
  } var_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_DONE = 2'd2
  } bt_state_e;

  localparam var_entry_t ENTRY_CLEAR = '{unassign: 1'b1, val: 1'b0, level: '0};

  // Build the entry stored for a freshly assigned variable.
  function automatic var_entry_t make_entry(input logic v, input logic [LVL_W_MAX-1:0] l);
    var_entry_t e;
    e.unassign = 1'b0;
    e.val      = v;
    e.level    = l;
    return e;
  endfunction

endpackage

// File: rtl/trail_stack.sv
// LIFO of assigned variable indices, in assignment order.
module trail_stack #(
  parameter  int DEPTH = 64,
  parameter  int W     = 6,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  top_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] top_idx;

  assign count_o = cnt_q;
  assign empty_o = (cnt_q == CW'(0));
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign top_idx = AW'(cnt_q - CW'(1));

  // Top-of-stack view; an empty stack presents index 0 so callers never see X.
  always_comb begin
    top_o = '0;
    if (!empty_o) begin
      top_o = mem_q[top_idx];
    end else begin
      top_o = '0;
    end
  end

  // Push has priority; pushes when full and pops when empty are ignored so the pointer never wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      cnt_q <= '0;
    end else if (push_i && !full_o) begin
      mem_q[AW'(cnt_q)] <= push_data_i;
      cnt_q             <= cnt_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      cnt_q <= cnt_q - CW'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

endmodule

// File: rtl/var_state_trail.sv
// Per-variable assignment state with a trail and a backtrack engine that
// unassigns trail entries above a target decision level, one per cycle.
module var_state_trail
  import var_state_pkg::*;
#(
  parameter  int NUM_VARS     = DEF_NUM_VARS,
  parameter  int NUM_RD_PORTS = DEF_NUM_RD_PORTS,
  parameter  int MAX_LEVEL    = DEF_MAX_LEVEL,
  localparam int VB           = $clog2(NUM_VARS),
  localparam int LB           = $clog2(MAX_LEVEL + 1)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [VB-1:0]                    wr_var,
  input  logic                             wr_val,
  input  logic [LB-1:0]                    wr_level,
  input  logic [NUM_RD_PORTS-1:0]          rd_en,
  input  logic [NUM_RD_PORTS-1:0][VB-1:0]  rd_var,
  output logic [NUM_RD_PORTS-1:0]          rd_val,
  output logic [NUM_RD_PORTS-1:0]          rd_unassign,
  output logic [NUM_RD_PORTS-1:0][LB-1:0]  rd_level,
  input  logic                             bt_req,
  input  logic [LB-1:0]                    bt_level,
  output logic                             busy,
  output logic                             bt_done,
  output logic [VB:0]                      trail_count,
  output logic                             err_double,
  output logic                             err_full,
  output logic                             err_busy
);

  var_entry_t           state_q [NUM_VARS];
  bt_state_e            fsm_q;
  logic [LB-1:0]        target_q;
  logic                 busy_q;
  logic                 bt_done_q;
  logic                 err_double_q;
  logic                 err_full_q;
  logic                 err_busy_q;

  logic [VB-1:0]        trail_top;
  logic [VB:0]          trail_cnt;
  logic                 trail_empty;
  logic                 trail_full;
  logic [LVL_W_MAX-1:0] top_level;
  logic                 wr_unassigned;

  logic                 wr_try;
  logic                 wr_ok;
  logic                 wr_double_d;
  logic                 wr_full_d;
  logic                 busy_err_d;
  logic                 pop_go;

  assign wr_unassigned = state_q[wr_var].unassign;
  assign top_level     = state_q[trail_top].level;

  // A write competes with nothing only when no backtrack is running or being requested.
  assign wr_try      = wr_en && !busy_q && !bt_req;
  assign wr_double_d = wr_try && !wr_unassigned;
  assign wr_full_d   = wr_try && wr_unassigned && trail_full;
  assign wr_ok       = wr_try && wr_unassigned && !trail_full;
  assign busy_err_d  = (busy_q && (wr_en || bt_req)) || (!busy_q && wr_en && bt_req);

  // Pop the newest trail entry while it sits strictly above the target level.
  assign pop_go = (fsm_q == ST_POP) && !trail_empty &&
                  (top_level > LVL_W_MAX'(target_q));

  trail_stack #(
    .DEPTH (NUM_VARS),
    .W     (VB)
  ) u_trail (
    .clock       (clock),
    .reset       (reset),
    .push_i      (wr_ok),
    .push_data_i (wr_var),
    .pop_i       (pop_go),
    .top_o       (trail_top),
    .count_o     (trail_cnt),
    .empty_o     (trail_empty),
    .full_o      (trail_full)
  );

  // Read ports see the stored state only; same-cycle writes are not forwarded.
  always_comb begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_val[p]      = 1'b0;
      rd_unassign[p] = 1'b1;
      rd_level[p]    = '0;
      if (rd_en[p]) begin
        rd_val[p]      = state_q[rd_var[p]].val;
        rd_unassign[p] = state_q[rd_var[p]].unassign;
        rd_level[p]    = state_q[rd_var[p]].level[LB-1:0];
      end else begin
        rd_val[p]      = 1'b0;
        rd_unassign[p] = 1'b1;
        rd_level[p]    = '0;
      end
    end
  end

  // Variable state array: accepted writes assign, backtrack pops clear; the two never coincide.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_VARS; i++) begin
        state_q[i] <= ENTRY_CLEAR;
      end
    end else if (wr_ok) begin
      state_q[wr_var] <= make_entry(wr_val, LVL_W_MAX'(wr_level));
    end else if (pop_go) begin
      state_q[trail_top] <= ENTRY_CLEAR;
    end else begin
      state_q[0] <= state_q[0];
    end
  end

  // Backtrack sequencer with registered busy and completion pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q     <= ST_IDLE;
      target_q  <= '0;
      busy_q    <= 1'b0;
      bt_done_q <= 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE, ST_DONE: begin
          bt_done_q <= 1'b0;
          if (bt_req) begin
            target_q <= bt_level;
            fsm_q    <= ST_POP;
            busy_q   <= 1'b1;
          end else begin
            fsm_q    <= ST_IDLE;
            busy_q   <= 1'b0;
          end
        end
        ST_POP: begin
          if (!pop_go) begin
            fsm_q     <= ST_DONE;
            busy_q    <= 1'b0;
            bt_done_q <= 1'b1;
          end else begin
            fsm_q     <= ST_POP;
            bt_done_q <= 1'b0;
          end
        end
        default: begin
          fsm_q     <= ST_IDLE;
          busy_q    <= 1'b0;
          bt_done_q <= 1'b0;
        end
      endcase
    end
  end

  // One-cycle error pulses for dropped requests.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_double_q <= 1'b0;
      err_full_q   <= 1'b0;
      err_busy_q   <= 1'b0;
    end else begin
      err_double_q <= wr_double_d;
      err_full_q   <= wr_full_d;
      err_busy_q   <= busy_err_d;
    end
  end

  assign busy        = busy_q;
  assign bt_done     = bt_done_q;
  assign trail_count = trail_cnt;
  assign err_double  = err_double_q;
  assign err_full    = err_full_q;
  assign err_busy    = err_busy_q;

endmodule

// File: tb/tb_var_state_trail.sv
// Bench for var_state_trail: directed steps plus random writes/backtracks
// checked against an array-and-queue model of variables and the trail.
module tb_var_state_trail;

  localparam int NV = 64;
  localparam int NP = 5;
  localparam int VB = 6;
  localparam int LB = 6;

  logic                    clock;
  logic                    reset;
  logic                    wr_en;
  logic [VB-1:0]           wr_var;
  logic                    wr_val;
  logic [LB-1:0]           wr_level;
  logic [NP-1:0]           rd_en;
  logic [NP-1:0][VB-1:0]   rd_var;
  logic [NP-1:0]           rd_val;
  logic [NP-1:0]           rd_unassign;
  logic [NP-1:0][LB-1:0]   rd_level;
  logic                    bt_req;
  logic [LB-1:0]           bt_level;
  logic                    busy;
  logic                    bt_done;
  logic [VB:0]             trail_count;
  logic                    err_double;
  logic                    err_full;
  logic                    err_busy;

  var_state_trail #(.NUM_VARS(NV), .NUM_RD_PORTS(NP), .MAX_LEVEL(63)) dut (
    .clock(clock), .reset(reset),
    .wr_en(wr_en), .wr_var(wr_var), .wr_val(wr_val), .wr_level(wr_level),
    .rd_en(rd_en), .rd_var(rd_var), .rd_val(rd_val), .rd_unassign(rd_unassign),
    .rd_level(rd_level), .bt_req(bt_req), .bt_level(bt_level), .busy(busy),
    .bt_done(bt_done), .trail_count(trail_count), .err_double(err_double),
    .err_full(err_full), .err_busy(err_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model: assignment per variable plus the trail as a queue.
  bit m_asg [NV];
  bit m_val [NV];
  int m_lvl [NV];
  int m_trail[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      m_asg[i] = 1'b0; m_val[i] = 1'b0; m_lvl[i] = 0;
    end
    m_trail.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en = 1'b0; bt_req = 1'b0;
    step(); step();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic check_quiet(input string tag);
    chk($sformatf("%s_busy", tag), busy, 0);
    chk($sformatf("%s_bt_done", tag), bt_done, 0);
    chk($sformatf("%s_err_double", tag), err_double, 0);
    chk($sformatf("%s_err_full", tag), err_full, 0);
    chk($sformatf("%s_err_busy", tag), err_busy, 0);
    chk($sformatf("%s_count", tag), trail_count, m_trail.size());
  endtask

  task automatic check_reads(input string tag, input int v[NP], input logic [NP-1:0] en);
    logic [NP-1:0]         ev;
    logic [NP-1:0]         eu;
    logic [NP-1:0][LB-1:0] el;
    for (int p = 0; p < NP; p++) begin
      rd_var[p] = VB'(v[p]);
      if (en[p] && m_asg[v[p]]) begin
        ev[p] = m_val[v[p]]; eu[p] = 1'b0; el[p] = LB'(m_lvl[v[p]]);
      end else begin
        ev[p] = 1'b0; eu[p] = 1'b1; el[p] = '0;
      end
    end
    rd_en = en;
    #1;
    chk($sformatf("%s_val", tag), rd_val, ev);
    chk($sformatf("%s_unassign", tag), rd_unassign, eu);
    chk($sformatf("%s_level", tag), rd_level, el);
  endtask

  task automatic rand_reads(input string tag);
    int v[NP];
    for (int p = 0; p < NP; p++) v[p] = $urandom_range(0, NV - 1);
    check_reads(tag, v, NP'($urandom_range(0, 31) | 4));
  endtask

  task automatic do_write(input int v, input bit val, input int lvl);
    bit exp_dbl;
    bit exp_full;
    exp_dbl  = m_asg[v];
    exp_full = !exp_dbl && (m_trail.size() == NV);
    wr_en = 1'b1; wr_var = VB'(v); wr_val = val; wr_level = LB'(lvl);
    rd_en = 5'b00001; rd_var[0] = VB'(v);
    #1;
    chk("no_bypass_unassign", rd_unassign[0], !m_asg[v]);
    step();
    wr_en = 1'b0;
    if (!exp_dbl && !exp_full) begin
      m_asg[v] = 1'b1; m_val[v] = val; m_lvl[v] = lvl;
      m_trail.push_back(v);
    end
    chk("wr_err_double", err_double, exp_dbl);
    chk("wr_err_full", err_full, exp_full);
    chk("wr_err_busy", err_busy, 0);
    chk("wr_count", trail_count, m_trail.size());
  endtask

  function automatic int first_free();
    for (int i = NV - 1; i >= 0; i--) if (!m_asg[i]) return i;
    return 0;
  endfunction

  // inject: 0 none, 1 write while busy, 2 write with bt_req, 3 second bt_req while busy
  task automatic do_bt(input int tgt, input int inject);
    int k;
    int i;
    int cyc;
    int busy_cnt;
    int inj;
    int v[NP];
    k = 0;
    i = m_trail.size();
    while (i > 0 && m_lvl[m_trail[i-1]] > tgt) begin i--; k++; end
    inj = first_free();
    bt_req = 1'b1; bt_level = LB'(tgt);
    if (inject == 2) begin
      wr_en = 1'b1; wr_var = VB'(inj); wr_val = 1'b1; wr_level = 6'd1;
    end
    step();
    bt_req = 1'b0; wr_en = 1'b0;
    cyc = 1;
    busy_cnt = 0;
    if (inject == 2) chk("bt_same_cycle_err_busy", err_busy, 1);
    while (bt_done !== 1'b1 && cyc < 200) begin
      if (busy === 1'b1) busy_cnt++;
      if (inject == 1 && cyc == 1) begin
        wr_en = 1'b1; wr_var = VB'(inj); wr_val = 1'b1; wr_level = 6'd5;
      end
      if (inject == 3 && cyc == 1) begin
        bt_req = 1'b1; bt_level = 6'd0;
      end
      step();
      wr_en = 1'b0; bt_req = 1'b0;
      cyc++;
      if ((inject == 1 || inject == 3) && cyc == 2) chk("bt_busy_err_busy", err_busy, 1);
    end
    chk("bt_latency", cyc, k + 2);
    chk("bt_busy_cycles", busy_cnt, k + 1);
    chk("bt_busy_at_done", busy, 0);
    for (int j = 0; j < k; j++) begin
      int pv;
      pv = m_trail.pop_back();
      m_asg[pv] = 1'b0; m_val[pv] = 1'b0; m_lvl[pv] = 0;
    end
    step();
    chk("bt_done_pulse_width", bt_done, 0);
    chk("bt_count", trail_count, m_trail.size());
    if (inject == 1 || inject == 2) begin
      v = '{inj, inj, 0, 1, 2};
      check_reads("bt_dropped_write", v, 5'b11111);
    end
  endtask

  initial begin
    int v[NP];
    int perm[NV];
    reset = 1'b1; wr_en = 1'b0; wr_var = '0; wr_val = 1'b0; wr_level = '0;
    rd_en = '0; rd_var = '0; bt_req = 1'b0; bt_level = '0;
    do_reset();
    check_quiet("reset");
    v = '{0, 1, 2, 3, 4};
    check_reads("reset_reads", v, 5'b11111);

    do_write(3, 1'b1, 1);
    do_write(7, 1'b0, 2);
    do_write(9, 1'b1, 3);
    v = '{3, 7, 9, 3, 7};
    check_reads("three_writes", v, 5'b10111);
    chk("three_writes_count", trail_count, 3);

    do_bt(1, 0);
    v = '{3, 7, 9, 3, 7};
    check_reads("bt_level1", v, 5'b11111);

    do_write(3, 1'b0, 4);
    v = '{3, 3, 3, 3, 3};
    check_reads("double_write", v, 5'b11111);

    do_write(10, 1'b1, 2);
    do_write(11, 1'b0, 3);
    do_bt(2, 1);
    do_write(12, 1'b1, 4);
    do_bt(3, 2);
    do_bt(63, 0);
    do_write(13, 1'b1, 5);
    do_bt(1, 3);
    check_quiet("directed_end");

    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        do_write($urandom_range(0, NV - 1), 1'($urandom_range(0, 1)), $urandom_range(1, 63));
      end else begin
        do_bt($urandom_range(0, 63), $urandom_range(0, 3));
      end
      rand_reads("random");
    end

    do_reset();
    check_quiet("refill_reset");
    for (int i = 0; i < NV; i++) perm[i] = i;
    for (int i = NV - 1; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < NV; i++) do_write(perm[i], 1'($urandom_range(0, 1)), $urandom_range(1, 63));
    chk("full_count", trail_count, NV);
    do_write(perm[5], 1'b1, 7);
    rand_reads("full_reads");
    do_bt(0, 0);
    chk("full_clear_count", trail_count, 0);
    rand_reads("full_clear_reads");

    for (int i = 0; i < 10; i++) do_write(i, 1'b1, i + 1);
    bt_req = 1'b1; bt_level = 6'd0;
    step();
    bt_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
    check_quiet("abort_reset");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_bt_done", bt_done, 0);
    end
    v = '{0, 1, 5, 8, 9};
    check_reads("abort_reads", v, 5'b11111);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
